// File: rtl/loeffler_pkg.sv
// Shared constants and helpers for the Loeffler DCT/IDCT datapaths.
// Rotation constants are round(value * 2^FRAC) with FRAC = 12.
package loeffler_pkg;

  localparam int FRAC = 12;

  localparam logic signed [15:0] C1    = 16'sd4017;
  localparam logic signed [15:0] S1    = 16'sd799;
  localparam logic signed [15:0] C3    = 16'sd3406;
  localparam logic signed [15:0] S3    = 16'sd2276;
  localparam logic signed [15:0] C6    = 16'sd1567;
  localparam logic signed [15:0] S6    = 16'sd3784;
  localparam logic signed [15:0] SQRT2 = 16'sd5793;

  // sqrt(2)*cos(6pi/16) and sqrt(2)*sin(6pi/16)
  localparam logic signed [15:0] R6C   = 16'sd2217;
  localparam logic signed [15:0] R6S   = 16'sd5352;

  function automatic int sat_out(input int v, input int ow);
    int hi;
    int lo;
    hi = (1 <<< (ow - 1)) - 1;
    lo = -(1 <<< (ow - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/loeffler_idct_1d_rot.sv
// Registered rotator: y0 = a*kc + b*ks, y1 = b*kc - a*ks.
// Three-multiply form sharing kc*(a+b); products rescaled by FRAC.
module loeffler_rot #(
  parameter int W = 28,
  parameter int FRAC = 12,
  parameter logic signed [15:0] KC = 16'sd4096,
  parameter logic signed [15:0] KS = 16'sd0
) (
  input  logic                clk,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] y1
);

  localparam int PW = W + 20;

  localparam logic signed [PW-1:0] KCW = PW'(KC);
  localparam logic signed [PW-1:0] KDF = PW'(KC) - PW'(KS);
  localparam logic signed [PW-1:0] KSM = PW'(KC) + PW'(KS);

  logic signed [PW-1:0] sum;
  logic signed [PW-1:0] m0;
  logic signed [PW-1:0] m1;
  logic signed [PW-1:0] m2;

  // shared product plus the two correction products
  always_comb begin
    sum = PW'(a) + PW'(b);
    m0  = sum * KCW;
    m1  = PW'(b) * KDF;
    m2  = PW'(a) * KSM;
  end

  // single output register, back to datapath scale
  always_ff @(posedge clk) begin
    y0 <= W'((m0 - m1) >>> FRAC);
    y1 <= W'((m0 - m2) >>> FRAC);
  end

endmodule

// File: rtl/loeffler_idct_1d.sv
// 1-D 8-point inverse DCT, Loeffler flow graph reversed, 4 stages.
// Datapath carries 4*x*2^FRAC until S3 drops the factor 4.
module loeffler_idct_1d #(
  parameter int IN_W = 12,
  parameter int OUT_W = 9,
  parameter int FRAC = loeffler_pkg::FRAC
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  win0,
  input  logic signed [IN_W-1:0]  win1,
  input  logic signed [IN_W-1:0]  win2,
  input  logic signed [IN_W-1:0]  win3,
  input  logic signed [IN_W-1:0]  win4,
  input  logic signed [IN_W-1:0]  win5,
  input  logic signed [IN_W-1:0]  win6,
  input  logic signed [IN_W-1:0]  win7,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out0,
  output logic signed [OUT_W-1:0] out1,
  output logic signed [OUT_W-1:0] out2,
  output logic signed [OUT_W-1:0] out3,
  output logic signed [OUT_W-1:0] out4,
  output logic signed [OUT_W-1:0] out5,
  output logic signed [OUT_W-1:0] out6,
  output logic signed [OUT_W-1:0] out7,
  output logic [2:0]              out_row,
  output logic                    out_last
);

  import loeffler_pkg::*;

  localparam int W  = IN_W + FRAC + 4;
  localparam int RW = W - FRAC;

  typedef logic signed [W-1:0] dw_t;

  localparam dw_t KR2  = dw_t'(SQRT2);
  localparam dw_t HALF = dw_t'(1 <<< (FRAC - 1));

  function automatic dw_t sx(input logic signed [IN_W-1:0] v);
    return dw_t'(v);
  endfunction

  logic [3:0] vld;
  logic [2:0] row;

  dw_t s1_z0, s1_z4, s1_z2, s1_z6;
  dw_t s1_a4, s1_a5, s1_a6, s1_a7;
  dw_t s2_p, s2_q, s2_t, s2_u;
  dw_t s2_o [4];
  dw_t e [4];
  dw_t s3_f [8];
  logic signed [RW-1:0] rnd [8];
  logic signed [OUT_W-1:0] q [8];

  // valid pipeline; reset discards rows in flight
  always_ff @(posedge clk) begin
    if (!rstn) vld <= '0;
    else       vld <= {vld[2:0], in_valid};
  end

  // row index within the 8-row block, advances per output row
  always_ff @(posedge clk) begin
    if (!rstn)       row <= '0;
    else if (vld[3]) row <= row + 3'd1;
  end

  // S1: sqrt2 scaling of even inputs, odd butterflies
  always_ff @(posedge clk) begin
    s1_z0 <= sx(win0) * KR2;
    s1_z4 <= sx(win4) * KR2;
    s1_z2 <= sx(win2) * KR2;
    s1_z6 <= sx(win6) * KR2;
    s1_a4 <= (sx(win1) - sx(win7)) * KR2
           + (sx(win5) <<< (FRAC + 1));
    s1_a6 <= (sx(win1) - sx(win7)) * KR2
           - (sx(win5) <<< (FRAC + 1));
    s1_a7 <= (sx(win1) + sx(win7)) * KR2
           + (sx(win3) <<< (FRAC + 1));
    s1_a5 <= (sx(win1) + sx(win7)) * KR2
           - (sx(win3) <<< (FRAC + 1));
  end

  // S2: DC/Nyquist butterfly alongside the rotators
  always_ff @(posedge clk) begin
    s2_p <= s1_z0 + s1_z4;
    s2_q <= s1_z0 - s1_z4;
  end

  loeffler_rot #(
    .W(W), .FRAC(FRAC), .KC(R6C), .KS(R6S)
  ) u_rot6 (
    .clk(clk), .a(s1_z6), .b(s1_z2),
    .y0(s2_t), .y1(s2_u)
  );

  loeffler_rot #(
    .W(W), .FRAC(FRAC), .KC(C3), .KS(S3)
  ) u_rot3 (
    .clk(clk), .a(s1_a7), .b(s1_a4),
    .y0(s2_o[0]), .y1(s2_o[3])
  );

  loeffler_rot #(
    .W(W), .FRAC(FRAC), .KC(C1), .KS(S1)
  ) u_rot1 (
    .clk(clk), .a(s1_a6), .b(s1_a5),
    .y0(s2_o[1]), .y1(s2_o[2])
  );

  // even-part butterflies feeding the recombination
  always_comb begin
    e[0] = s2_p + s2_t;
    e[1] = s2_q + s2_u;
    e[2] = s2_q - s2_u;
    e[3] = s2_p - s2_t;
  end

  // S3: even/odd recombination, drop the 4x gain
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      s3_f[n]     <= (e[n] + s2_o[n]) >>> 2;
      s3_f[7 - n] <= (e[n] - s2_o[n]) >>> 2;
    end
  end

  // round half up to integer samples
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      rnd[n] = RW'((s3_f[n] + HALF) >>> FRAC);
    end
  end

  // S4: saturate; hold while no valid row arrives
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int n = 0; n < 8; n++) q[n] <= '0;
    end else if (vld[2]) begin
      for (int n = 0; n < 8; n++) begin
        q[n] <= OUT_W'(sat_out(int'(rnd[n]), OUT_W));
      end
    end
  end

  assign out_valid = vld[3];
  assign out_row   = row;
  assign out_last  = vld[3] & (row == 3'd7);

  assign out0 = q[0];
  assign out1 = q[1];
  assign out2 = q[2];
  assign out3 = q[3];
  assign out4 = q[4];
  assign out5 = q[5];
  assign out6 = q[6];
  assign out7 = q[7];

endmodule
